// File: rtl/decode_pkg.sv
// Shared decode encodings: opcodes, control-field enums and the decoder output bundle.
package decode_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  // mem_size = {unsigned, size[1:0]}, which is exactly funct3 of loads/stores
  localparam logic [1:0]  MEM_SZ_B         = 2'b00;
  localparam logic [1:0]  MEM_SZ_H         = 2'b01;
  localparam logic [1:0]  MEM_SZ_W         = 2'b10;
  localparam int unsigned MEM_UNSIGNED_BIT = 2;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
    ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
    ALU_OR   = 5'd8, ALU_AND = 5'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2, WB_CSR = 3'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    CSR_NONE  = 4'd0, CSR_RW     = 4'd1, CSR_RS   = 4'd2, CSR_RC  = 4'd3,
    CSR_ECALL = 4'd4, CSR_EBREAK = 4'd5, CSR_MRET = 4'd6, CSR_WFI = 4'd7,
    CSR_FENCE = 4'd8
  } csr_cmd_e;

  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO, OP1_ZIMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_ZERO}           op2_sel_e;

  typedef struct packed {
    logic        illegal;
    logic        use_rs1;
    logic        use_rs2;
    logic        rd_wen;
    logic        mem_we;
    logic        mem_re;
    logic        is_branch;
    alu_op_e     alu_op;
    logic [2:0]  mem_size;
    wb_sel_e     wb_sel;
    csr_cmd_e    csr_cmd;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] imm;
  } ctrl_t;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV32I + Zicsr decoder: instruction word -> control bundle.
module inst_decoder
  import decode_pkg::*;
#(
  parameter bit RVE = 1'b0
) (
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal, writes_rd, rve_bad;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign f3     = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign f7     = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Decode opcode/funct fields; anything unmatched (including all-zero) collapses to an empty bundle
  always_comb begin
    ctrl_o    = '0;
    legal     = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1;
        ctrl_o.op1_sel = OP1_ZERO; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1;
        ctrl_o.op1_sel = OP1_PC; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_u;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; ctrl_o.wb_sel = WB_PC4;
        ctrl_o.op1_sel = OP1_PC; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_j;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); writes_rd = 1'b1; ctrl_o.wb_sel = WB_PC4;
        ctrl_o.use_rs1 = 1'b1; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_i;
      end
      OPC_BRANCH: begin
        legal = (f3[2:1] != 2'b01); ctrl_o.is_branch = 1'b1;
        ctrl_o.use_rs1 = 1'b1; ctrl_o.use_rs2 = 1'b1;
        ctrl_o.op1_sel = OP1_PC; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_b;
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        writes_rd = 1'b1; ctrl_o.mem_re = 1'b1; ctrl_o.mem_size = f3; ctrl_o.wb_sel = WB_MEM;
        ctrl_o.use_rs1 = 1'b1; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_i;
      end
      OPC_STORE: begin
        legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        ctrl_o.mem_we = 1'b1; ctrl_o.mem_size = f3;
        ctrl_o.use_rs1 = 1'b1; ctrl_o.use_rs2 = 1'b1; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_s;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        writes_rd = 1'b1; ctrl_o.alu_op = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
        ctrl_o.use_rs1 = 1'b1; ctrl_o.op2_sel = OP2_IMM; ctrl_o.imm = imm_i;
      end
      OPC_OP: begin
        legal = (f7 == 7'b0000000) || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        writes_rd = 1'b1; ctrl_o.alu_op = alu_from_f3(f3, f7[5]);
        ctrl_o.use_rs1 = 1'b1; ctrl_o.use_rs2 = 1'b1;
      end
      OPC_MISCMEM: begin
        legal = (f3 == 3'b000); ctrl_o.csr_cmd = CSR_FENCE;
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          legal = 1'b1;
          case (inst_i)
            32'h0000_0073: ctrl_o.csr_cmd = CSR_ECALL;
            32'h0010_0073: ctrl_o.csr_cmd = CSR_EBREAK;
            32'h3020_0073: ctrl_o.csr_cmd = CSR_MRET;
            32'h1050_0073: ctrl_o.csr_cmd = CSR_WFI;
            default:       legal = 1'b0;
          endcase
        end else if (f3 != 3'b100) begin
          legal = 1'b1; writes_rd = 1'b1; ctrl_o.wb_sel = WB_CSR;
          ctrl_o.use_rs1 = !f3[2];
          ctrl_o.op1_sel = f3[2] ? OP1_ZIMM : OP1_RS1;
          ctrl_o.op2_sel = OP2_ZERO;
          case (f3[1:0])
            2'b01:   ctrl_o.csr_cmd = CSR_RW;
            2'b10:   ctrl_o.csr_cmd = CSR_RS;
            default: ctrl_o.csr_cmd = CSR_RC;
          endcase
        end
      end
      default: legal = 1'b0;
    endcase

    rve_bad = RVE && ((ctrl_o.use_rs1 && rs1[4]) || (ctrl_o.use_rs2 && rs2[4]) || (writes_rd && rd[4]));
    ctrl_o.rd_wen = writes_rd && (rd != 5'd0);
    // Illegal words drop every enable and source use so they never stall on forwarding
    if (!legal || rve_bad) begin
      ctrl_o         = '0;
      ctrl_o.illegal = (inst_i != '0);
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: operand forwarding, load-use hazard stall and the issue pipeline register.
module decode_issue_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter bit          RVE     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  input  logic                    flush,
  output logic [4:0]              rf_rs1_addr,
  output logic [4:0]              rf_rs2_addr,
  input  logic [XLEN-1:0]         rf_rs1_data,
  input  logic [XLEN-1:0]         rf_rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_rs2,
  output logic [4:0]              out_rd,
  output logic                    out_rd_wen,
  output logic                    out_mem_we,
  output logic                    out_mem_re,
  output logic                    out_illegal,
  output logic                    out_br_taken,
  output logic [4:0]              out_alu_op,
  output logic [2:0]              out_mem_size,
  output logic [2:0]              out_wb_sel,
  output logic [3:0]              out_csr_cmd,
  output logic [11:0]             out_csr_addr,
  output logic [7:0]              stall_cnt
);

  ctrl_t           ctrl;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_x, op1_d, op2_d;
  logic            rs1_ok, rs2_ok, rs1_hit, rs2_hit, hazard, accept, br_d;
  logic [11:0]     csr_addr_d;

  logic            out_valid_q, rd_wen_q, mem_we_q, mem_re_q, illegal_q, br_q;
  logic [XLEN-1:0] pc_q, op1_q, op2_q, rs2v_q;
  logic [4:0]      rd_q, alu_op_q;
  logic [2:0]      mem_size_q, wb_sel_q;
  logic [3:0]      csr_cmd_q;
  logic [11:0]     csr_addr_q;
  logic [7:0]      stall_q;

  inst_decoder #(.RVE(RVE)) u_dec (
    .inst_i (in_inst),
    .ctrl_o (ctrl)
  );

  assign rs1         = in_inst[19:15];
  assign rs2         = in_inst[24:20];
  assign rf_rs1_addr = rs1;
  assign rf_rs2_addr = rs2;
  assign imm_x       = XLEN'($signed(ctrl.imm));

  // Operand resolution: youngest matching forwarding source wins, then regfile, x0 forced to zero
  always_comb begin
    rs1_val = rf_rs1_data; rs1_ok = 1'b1; rs1_hit = 1'b0;
    rs2_val = rf_rs2_data; rs2_ok = 1'b1; rs2_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!rs1_hit && fwd_valid[i] && (fwd_addr[i*5 +: 5] == rs1)) begin
        rs1_hit = 1'b1; rs1_val = fwd_data[i*XLEN +: XLEN]; rs1_ok = fwd_data_ok[i];
      end
      if (!rs2_hit && fwd_valid[i] && (fwd_addr[i*5 +: 5] == rs2)) begin
        rs2_hit = 1'b1; rs2_val = fwd_data[i*XLEN +: XLEN]; rs2_ok = fwd_data_ok[i];
      end
    end
    if (rs1 == 5'd0) begin rs1_val = '0; rs1_ok = 1'b1; end
    if (rs2 == 5'd0) begin rs2_val = '0; rs2_ok = 1'b1; end
  end

  assign hazard   = in_valid && ((ctrl.use_rs1 && !rs1_ok) || (ctrl.use_rs2 && !rs2_ok));
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Operand muxing, branch evaluation and CSR address selection for the next issue slot
  always_comb begin
    case (ctrl.op1_sel)
      OP1_PC:   op1_d = in_pc;
      OP1_ZERO: op1_d = '0;
      OP1_ZIMM: op1_d = XLEN'(rs1);
      default:  op1_d = rs1_val;
    endcase
    if (ctrl.illegal) op1_d = XLEN'(in_inst);
    case (ctrl.op2_sel)
      OP2_RS2: op2_d = rs2_val;
      OP2_IMM: op2_d = imm_x;
      default: op2_d = '0;
    endcase
    br_d = 1'b0;
    if (ctrl.is_branch) begin
      case (in_inst[14:12])
        3'b000:  br_d = (rs1_val == rs2_val);
        3'b001:  br_d = (rs1_val != rs2_val);
        3'b100:  br_d = ($signed(rs1_val) <  $signed(rs2_val));
        3'b101:  br_d = ($signed(rs1_val) >= $signed(rs2_val));
        3'b110:  br_d = (rs1_val <  rs2_val);
        3'b111:  br_d = (rs1_val >= rs2_val);
        default: br_d = 1'b0;
      endcase
    end
    csr_addr_d = (ctrl.wb_sel == WB_CSR) ? in_inst[31:20] : '0;
  end

  // Issue register: flush kills, accept loads, downstream consume empties, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; pc_q <= '0; op1_q <= '0; op2_q <= '0; rs2v_q <= '0;
      rd_q <= '0; rd_wen_q <= 1'b0; mem_we_q <= 1'b0; mem_re_q <= 1'b0;
      illegal_q <= 1'b0; br_q <= 1'b0; alu_op_q <= '0; mem_size_q <= '0;
      wb_sel_q <= '0; csr_cmd_q <= '0; csr_addr_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= in_pc;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rs2v_q      <= rs2_val;
      rd_q        <= in_inst[11:7];
      rd_wen_q    <= ctrl.rd_wen;
      mem_we_q    <= ctrl.mem_we;
      mem_re_q    <= ctrl.mem_re;
      illegal_q   <= ctrl.illegal;
      br_q        <= br_d;
      alu_op_q    <= ctrl.alu_op;
      mem_size_q  <= ctrl.mem_size;
      wb_sel_q    <= ctrl.wb_sel;
      csr_cmd_q   <= ctrl.csr_cmd;
      csr_addr_q  <= csr_addr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating count of cycles lost to a not-yet-available forwarded operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_q <= '0;
    else if (hazard && !flush && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = pc_q;
  assign out_op1      = op1_q;
  assign out_op2      = op2_q;
  assign out_rs2      = rs2v_q;
  assign out_rd       = rd_q;
  assign out_rd_wen   = rd_wen_q;
  assign out_mem_we   = mem_we_q;
  assign out_mem_re   = mem_re_q;
  assign out_illegal  = illegal_q;
  assign out_br_taken = br_q;
  assign out_alu_op   = alu_op_q;
  assign out_mem_size = mem_size_q;
  assign out_wb_sel   = wb_sel_q;
  assign out_csr_cmd  = csr_cmd_q;
  assign out_csr_addr = csr_addr_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage (RVE build, two forwarding sources).
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst, rf_rs1_data, rf_rs2_data;
  logic [1:0]  fwd_valid, fwd_data_ok;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;

  logic        in_ready, out_valid, out_rd_wen, out_mem_we, out_mem_re, out_illegal, out_br_taken;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, out_rd, out_alu_op;
  logic [31:0] out_pc, out_op1, out_op2, out_rs2;
  logic [2:0]  out_mem_size, out_wb_sel;
  logic [3:0]  out_csr_cmd;
  logic [11:0] out_csr_addr;
  logic [7:0]  stall_cnt;

  int unsigned total = 0, passed = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.XLEN(32), .NUM_FWD(2), .RVE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_mem_we(out_mem_we), .out_mem_re(out_mem_re),
    .out_illegal(out_illegal), .out_br_taken(out_br_taken), .out_alu_op(out_alu_op),
    .out_mem_size(out_mem_size), .out_wb_sel(out_wb_sel), .out_csr_cmd(out_csr_cmd),
    .out_csr_addr(out_csr_addr), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_inst = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    fwd_valid = '0; fwd_data_ok = '0; fwd_addr = '0; fwd_data = '0;
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (stall_cnt !== 8'd0) $display("FAIL reset_stall: got %0d want 0", stall_cnt); else passed++;
    total++; if (out_op1 !== 32'h0) $display("FAIL reset_op1: got %h want 0", out_op1); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_addi();
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL addi_ready: got %b want 1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_op2 !== 32'd5) $display("FAIL addi_op2: got %h want 5", out_op2); else passed++;
    total++; if (out_op1 !== 32'd0) $display("FAIL addi_op1: got %h want 0", out_op1); else passed++;
    total++; if (out_rd !== 5'd1) $display("FAIL addi_rd: got %0d want 1", out_rd); else passed++;
    total++; if (out_rd_wen !== 1'b1) $display("FAIL addi_wen: got %b want 1", out_rd_wen); else passed++;
    total++; if (out_pc !== 32'h100) $display("FAIL addi_pc: got %h want 100", out_pc); else passed++;
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL addi_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_forward_priority();
    in_valid = 1'b1; in_inst = 32'h0020_81B3; rf_rs1_data = 32'h77; rf_rs2_data = 32'd3;
    fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'hB, 32'hA}; fwd_data_ok = 2'b11;
    #1;
    total++; if (rf_rs1_addr !== 5'd1 || rf_rs2_addr !== 5'd2)
      $display("FAIL fwd_rf_addr: got %0d/%0d want 1/2", rf_rs1_addr, rf_rs2_addr); else passed++;
    step();
    total++; if (out_op1 !== 32'hA) $display("FAIL fwd_youngest: got %h want a", out_op1); else passed++;
    total++; if (out_op2 !== 32'd3) $display("FAIL fwd_rf_op2: got %h want 3", out_op2); else passed++;
    total++; if (out_rd !== 5'd3) $display("FAIL fwd_rd: got %0d want 3", out_rd); else passed++;
    fwd_data_ok = 2'b01;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL fwd_override_ready: got %b want 1", in_ready); else passed++;
    step();
    total++; if (out_op1 !== 32'hA) $display("FAIL fwd_override_op1: got %h want a", out_op1); else passed++;
    fwd_addr = {5'd1, 5'd2}; fwd_data = {32'hB, 32'h22}; fwd_data_ok = 2'b11;
    step();
    total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", out_valid); else passed++;
    total++; if (out_op1 !== 32'hB || out_op2 !== 32'h22)
      $display("FAIL fwd_both: got %h/%h want b/22", out_op1, out_op2); else passed++;
    in_valid = 1'b0; fwd_valid = 2'b00;
    step();
  endtask

  task automatic test_hazard();
    in_valid = 1'b1; in_inst = 32'h0020_81B3; rf_rs2_data = 32'd3;
    fwd_valid = 2'b10; fwd_addr = {5'd1, 5'd0}; fwd_data = {32'h99, 32'h0}; fwd_data_ok = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL hazard_ready: cycle %0d got %b want 0", c, in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b0) $display("FAIL hazard_valid: cycle %0d got %b want 0", c, out_valid); else passed++;
    end
    total++; if (stall_cnt !== 8'd2) $display("FAIL hazard_stall: got %0d want 2", stall_cnt); else passed++;
    fwd_data_ok = 2'b10;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL hazard_release: got %b want 1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_op1 !== 32'h99)
      $display("FAIL hazard_issue: got v=%b op1=%h want v=1 op1=99", out_valid, out_op1); else passed++;
    in_valid = 1'b0; fwd_data_ok = 2'b00;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL idle_hazard_ready: got %b want 1", in_ready); else passed++;
    step();
    total++; if (stall_cnt !== 8'd2) $display("FAIL idle_no_count: got %0d want 2", stall_cnt); else passed++;
    fwd_valid = 2'b00;
  endtask

  task automatic test_backpressure_flush();
    in_valid = 1'b1; in_inst = 32'h0050_0093; out_ready = 1'b1;
    step();
    in_inst = 32'h0070_0113; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready: cycle %0d got %b want 0", c, in_ready); else passed++;
      step();
      total++; if (out_valid !== 1'b1 || out_op2 !== 32'd5 || out_rd !== 5'd1)
        $display("FAIL bp_hold: cycle %0d got v=%b op2=%h rd=%0d want 1/5/1", c, out_valid, out_op2, out_rd); else passed++;
    end
    flush = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else passed++;
    flush = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_branch();
    logic [31:0] insts [4] = '{32'h0020_8463, 32'h0020_8463, 32'h0020_C463, 32'h0020_E463};
    logic [31:0] a     [4] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b     [4] = '{32'd5, 32'd6, 32'd1, 32'd1};
    logic        exp   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    in_valid = 1'b1; in_pc = 32'h1000;
    for (int k = 0; k < 4; k++) begin
      in_inst = insts[k]; rf_rs1_data = a[k]; rf_rs2_data = b[k];
      step();
      total++; if (out_br_taken !== exp[k]) $display("FAIL branch_%0d: got %b want %b", k, out_br_taken, exp[k]); else passed++;
    end
    total++; if (out_op1 !== 32'h1000 || out_op2 !== 32'd8)
      $display("FAIL branch_target_ops: got %h/%h want 1000/8", out_op1, out_op2); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mem_csr();
    in_valid = 1'b1; rf_rs1_data = 32'h100; rf_rs2_data = 32'hDEAD;
    in_inst = 32'h0080_A283;
    step();
    total++; if (out_mem_re !== 1'b1 || out_mem_we !== 1'b0 || out_mem_size !== 3'd2 || out_wb_sel !== 3'd1)
      $display("FAIL lw_ctrl: got re=%b we=%b sz=%0d wb=%0d want 1/0/2/1", out_mem_re, out_mem_we, out_mem_size, out_wb_sel); else passed++;
    total++; if (out_op1 !== 32'h100 || out_op2 !== 32'd8 || out_rd !== 5'd5)
      $display("FAIL lw_ops: got %h/%h rd=%0d want 100/8/5", out_op1, out_op2, out_rd); else passed++;
    in_inst = 32'h0020_A223;
    step();
    total++; if (out_mem_we !== 1'b1 || out_rd_wen !== 1'b0 || out_rs2 !== 32'hDEAD || out_op2 !== 32'd4)
      $display("FAIL sw: got we=%b wen=%b rs2=%h op2=%h want 1/0/dead/4", out_mem_we, out_rd_wen, out_rs2, out_op2); else passed++;
    in_inst = 32'h3053_D2F3;
    step();
    total++; if (out_csr_cmd !== 4'd1 || out_csr_addr !== 12'h305 || out_op1 !== 32'd7 || out_wb_sel !== 3'd3)
      $display("FAIL csrrwi: got cmd=%0d addr=%h op1=%h wb=%0d want 1/305/7/3", out_csr_cmd, out_csr_addr, out_op1, out_wb_sel); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal_nop();
    in_valid = 1'b1; in_inst = 32'h0;
    step();
    total++; if (out_valid !== 1'b1 || out_illegal !== 1'b0 || out_rd_wen !== 1'b0 || out_mem_we !== 1'b0 || out_mem_re !== 1'b0)
      $display("FAIL nop: got v=%b ill=%b wen=%b we=%b re=%b want 1/0/0/0/0", out_valid, out_illegal, out_rd_wen, out_mem_we, out_mem_re); else passed++;
    in_inst = 32'hFFFF_FFFF;
    step();
    total++; if (out_illegal !== 1'b1 || out_rd_wen !== 1'b0 || out_op1 !== 32'hFFFF_FFFF)
      $display("FAIL illegal_opc: got ill=%b wen=%b op1=%h want 1/0/ffffffff", out_illegal, out_rd_wen, out_op1); else passed++;
    in_inst = 32'h0020_88B3;
    step();
    total++; if (out_illegal !== 1'b1 || out_rd_wen !== 1'b0 || out_mem_we !== 1'b0 || out_op1 !== 32'h0020_88B3)
      $display("FAIL rve_rd17: got ill=%b wen=%b we=%b op1=%h want 1/0/0/002088b3", out_illegal, out_rd_wen, out_mem_we, out_op1); else passed++;
    in_inst = 32'h0;
    step();
    total++; if (out_illegal !== 1'b0) $display("FAIL nop_after_illegal: got %b want 0", out_illegal); else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_saturation_and_reset();
    in_valid = 1'b1; in_inst = 32'h0020_81B3;
    fwd_valid = 2'b10; fwd_addr = {5'd1, 5'd0}; fwd_data_ok = 2'b00;
    for (int c = 0; c < 260; c++) step();
    total++; if (stall_cnt !== 8'd255) $display("FAIL stall_saturate: got %0d want 255", stall_cnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL stall_no_issue: got %b want 0", out_valid); else passed++;
    fwd_valid = 2'b00; in_inst = 32'h0050_0093;
    step();
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || stall_cnt !== 8'd0 || out_op2 !== 32'd0)
      $display("FAIL async_reset: got v=%b stall=%0d op2=%h want 0/0/0", out_valid, stall_cnt, out_op2); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_held: got %b want 0", out_valid); else passed++;
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", in_ready); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || out_op2 !== 32'd5)
      $display("FAIL post_reset_accept: got v=%b op2=%h want 1/5", out_valid, out_op2); else passed++;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_forward_priority();
    test_hazard();
    test_backpressure_flush();
    test_branch();
    test_mem_csr();
    test_illegal_nop();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
